// File: rtl/ibex_pkg.sv
// Shared types for the retirement-trace scheduler.
//   trace_rec_t          packed 106-bit trace record, pc in the LSBs
//   trace_sched_state_e  scheduler state (IDLE / RUN / DRAIN)
package ibex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } trace_sched_state_e;

  typedef struct packed {
    logic        gap;       // first record accepted after one or more drops
    logic [1:0]  mode;
    logic        intr;
    logic        trap;
    logic [31:0] rd_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] insn;
    logic [31:0] pc;
  } trace_rec_t;

  localparam int unsigned TraceRecW = $bits(trace_rec_t);

endpackage

// File: rtl/ibex_trace_sched_if.sv
// Bundles the RVFI retirement port and the trace output stream.
//   rvfi_*          retirement information from the core (no back-pressure)
//   trace_valid_o   record available on trace_data_o
//   trace_ready_i   consumer accepts the record
//   trace_data_o    packed trace record
// Handshake: a record transfers in every cycle where trace_valid_o and
// trace_ready_i are both 1. trace_valid_o never depends on trace_ready_i,
// and trace_data_o is held stable while valid is high and ready is low.
// Modports: master = core/consumer side, slave = scheduler.
interface ibex_trace_sched_if;
  import ibex_pkg::*;

  logic        rvfi_valid;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_insn;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic        rvfi_trap;
  logic        rvfi_intr;
  logic [1:0]  rvfi_mode;
  logic        trace_valid_o;
  logic        trace_ready_i;
  trace_rec_t  trace_data_o;

  modport master (
    output rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
    output rvfi_trap, rvfi_intr, rvfi_mode, trace_ready_i,
    input  trace_valid_o, trace_data_o
  );

  modport slave (
    input  rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
    input  rvfi_trap, rvfi_intr, rvfi_mode, trace_ready_i,
    output trace_valid_o, trace_data_o
  );

endinterface

// File: rtl/ibex_trace_fifo.sv
// Generic synchronous FIFO.
//   clk, rst  clock, asynchronous active-high reset
//   push      write wdata (ignored when full unless pop is also high)
//   pop       advance the read pointer (ignored when empty)
//   flush     empty the FIFO; overrides push and pop
//   rdata     head entry, read straight from storage registers
//   full, empty, level  occupancy status
// Pointers carry one extra wrap bit: equal indices with differing wrap
// bits means full, identical pointers means empty.
module ibex_trace_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);
  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = 1;

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign level = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      // When full, the slot being written is the one being popped this cycle;
      // the read side still sees the old value until the edge.
      if (push && (!full || pop)) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + PtrOne;
      end
      if (pop && !empty) rptr <= rptr + PtrOne;
    end
  end

endmodule

// File: rtl/ibex_trace_sched.sv
// Retirement-trace buffer and scheduler.
//   clk, rst     clock, asynchronous active-high reset
//   enable_i     tracing enable (level)
//   flush_i      single-cycle pulse: discard buffered records, clear drop count
//   bus          RVFI input and trace output stream (slave modport)
//   level_o      FIFO occupancy
//   drop_cnt_o   saturating count of records dropped since reset/flush
//   busy_o       state is not IDLE (registered)
//   state_o      current scheduler state, for observation
// The core is never stalled: a retirement arriving while the FIFO is full
// and not being popped is dropped, counted, and the next accepted record
// is tagged with gap=1.
module ibex_trace_sched
  import ibex_pkg::*;
#(
  parameter int unsigned Depth    = 8,
  parameter int unsigned DropCntW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic                    flush_i,
  ibex_trace_sched_if.slave       bus,
  output logic [$clog2(Depth):0]  level_o,
  output logic [DropCntW-1:0]     drop_cnt_o,
  output logic                    busy_o,
  output trace_sched_state_e      state_o
);
  localparam int unsigned LvlW = $clog2(Depth) + 1;
  localparam logic [LvlW-1:0]     LvlOne = 1;
  localparam logic [DropCntW-1:0] CntOne = 1;

  trace_sched_state_e state;
  trace_rec_t         rec;
  logic               gap_pending;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_req;
  logic               pop;
  logic               accept;
  logic               drop;
  logic               drain_done;

  assign push_req = (state == RUN) && bus.rvfi_valid;
  assign pop      = bus.trace_valid_o && bus.trace_ready_i;
  assign accept   = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;
  // FIFO will be empty after this edge (DRAIN never pushes).
  assign drain_done = fifo_empty || ((level_o == LvlOne) && pop);

  assign rec = {gap_pending, bus.rvfi_mode, bus.rvfi_intr, bus.rvfi_trap,
                bus.rvfi_rd_wdata, bus.rvfi_rd_addr, bus.rvfi_insn,
                bus.rvfi_pc_rdata};

  assign bus.trace_valid_o = !fifo_empty;
  assign state_o           = state;

  ibex_trace_fifo #(
    .Width(TraceRecW),
    .Depth(Depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .flush (flush_i),
    .wdata (rec),
    .rdata (bus.trace_data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  // Scheduler state machine with registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy_o <= 1'b0;
    end else if (flush_i) begin
      if (state == DRAIN) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: if (enable_i) begin
          state  <= RUN;
          busy_o <= 1'b1;
        end
        RUN: if (!enable_i) state <= DRAIN;
        DRAIN: begin
          if (enable_i) begin
            state <= RUN;
          end else if (drain_done) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Drop accounting and gap marking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_o  <= '0;
      gap_pending <= 1'b0;
    end else if (flush_i) begin
      drop_cnt_o  <= '0;
      gap_pending <= 1'b0;
    end else begin
      if (accept) gap_pending <= 1'b0;
      else if (drop) gap_pending <= 1'b1;
      if (drop && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + CntOne;
    end
  end

endmodule
